// File: rtl/onchip_mem_loader_pkg.sv
// Shared types and constants for the on-chip RAM byte-stream loader.
package onchip_mem_loader_pkg;

  localparam int unsigned LOADER_DEPTH = 5120;
  localparam int unsigned LANES        = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/onchip_mem_loader_packer.sv
// Little-endian byte-to-word packer: bytes shift in at the top, so the first byte lands in [7:0].
module onchip_mem_loader_packer
  import onchip_mem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 clear,
  input  logic [7:0]           data,
  output logic [LANES*8-1:0]   word,
  output logic                 full
);

  localparam int unsigned IDX_W = $clog2(LANES);

  logic [LANES*8-1:0] word_q, word_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (load) begin
      word_d = {data, word_q[LANES*8-1:8]};
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  // Flags the load that completes a word, so the FSM can leave COLLECT on that edge.
  assign full = load && !clear && (idx_q == IDX_W'(LANES - 1));
  assign word = word_q;

endmodule

// File: rtl/onchip_mem_loader.sv
// Byte-stream loader for the 5120x32 on-chip RAM: FSM, counters, range check, checksum.
// Optional checksum accumulator enabled by defining ONCHIP_MEM_LOADER_CHECKSUM_EN.
module onchip_mem_loader
  import onchip_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DEPTH  = LOADER_DEPTH,
  parameter int unsigned CNT_W  = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam int unsigned SUM_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  wr_q, wr_d;
  logic [CNT_W-1:0]  wr_inc;
  logic              write_q, write_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              pk_load, pk_clear, pk_full;
  logic [31:0]       pk_word;

  logic [SUM_W-1:0]  end_addr;
  logic              range_bad;

  assign end_addr  = SUM_W'(base_addr) + SUM_W'(word_count);
  assign range_bad = (word_count == '0) || (end_addr > SUM_W'(DEPTH));
  assign wr_inc    = wr_q + CNT_W'(1);

  onchip_mem_loader_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pk_load),
    .clear   (pk_clear),
    .data    (s_data),
    .word    (pk_word),
    .full    (pk_full)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    error_d  = 1'b0;
    pk_load  = 1'b0;
    pk_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (range_bad) begin
            error_d = 1'b1;
          end else begin
            addr_d   = base_addr;
            cnt_d    = word_count;
            wr_d     = '0;
            pk_clear = 1'b1;
            state_d  = COLLECT;
          end
        end
      end
      COLLECT: begin
        pk_load = s_valid;
        if (pk_full) state_d = WRITE;
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        wr_d    = wr_inc;
        state_d = (wr_inc == cnt_q) ? DONE : COLLECT;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies of the next-state decode, so they track state_q exactly.
    write_d   = (state_d == WRITE);
    s_ready_d = (state_d == COLLECT);
    busy_d    = write_d || s_ready_d;
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_q      <= '0;
      write_q   <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      write_q   <= write_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign address    = addr_q;
  assign byteenable = {4{write_q}};
  assign chipselect = write_q;
  assign write      = write_q;
  assign writedata  = pk_word;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

`ifdef ONCHIP_MEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (pk_clear)     sum_d = '0;
    else if (write_q) sum_d = sum_q + pk_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_onchip_mem_loader.sv
// Randomized self-checking bench for onchip_mem_loader against a word-list reference model.
module tb_onchip_mem_loader;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DEPTH  = 5120;
  localparam int unsigned CNT_W  = 14;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              busy;
  logic              done;
  logic              error;
  logic [31:0]       checksum;

  onchip_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .address    (address),
    .byteenable (byteenable),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int                cyc = 0;
  int                last_wr_cyc = 0;
  int                done_cnt = 0;
  int                err_cnt = 0;
  bit                exact_spacing = 1'b0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  logic [7:0]        bytes_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (write) begin
      chk("wr_byteenable", 32'(byteenable), 32'hF);
      chk("wr_chipselect", 32'(chipselect), 32'h1);
      chk("wr_s_ready", 32'(s_ready), 32'h0);
      if (wr_addr.size() > 0) begin
        if (exact_spacing) chk("wr_spacing", 32'(cyc - last_wr_cyc), 32'd5);
        else               chk("wr_spacing_min", 32'(cyc - last_wr_cyc >= 5), 32'h1);
      end
      wr_addr.push_back(address);
      wr_data.push_back(writedata);
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      chk("done_busy", 32'(busy), 32'h0);
      chk("done_latency", 32'(cyc - last_wr_cyc), 32'd1);
    end
    if (error) err_cnt++;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'h0);
    chk({tag, "_address"}, 32'(address), 32'h0);
    chk({tag, "_byteenable"}, 32'(byteenable), 32'h0);
    chk({tag, "_chipselect"}, 32'(chipselect), 32'h0);
    chk({tag, "_write"}, 32'(write), 32'h0);
    chk({tag, "_writedata"}, writedata, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_error"}, 32'(error), 32'h0);
    chk({tag, "_checksum"}, checksum, 32'h0);
  endtask

  task automatic fill_random(input int unsigned nwords);
    bytes_q.delete();
    for (int unsigned i = 0; i < nwords * 4; i++) bytes_q.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    if (gap) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    acc = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (!acc) chk("byte_timeout", 32'h0, 32'h1);
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    base_addr  = ADDR_W'($urandom);
    word_count = CNT_W'($urandom);
  endtask

  // Reference model: word i is bytes 4i..4i+3 little-endian at base+i; checksum is their sum.
  task automatic run_load(input string tag, input int unsigned base, input int unsigned count,
                          input bit gap, input bit busy_start);
    logic [31:0] exp_words[$];
    logic [31:0] exp_sum;
    int          e0, d0;
    bit          got_done;
    exp_sum = '0;
    for (int unsigned i = 0; i < count; i++) begin
      exp_words.push_back({bytes_q[4*i+3], bytes_q[4*i+2], bytes_q[4*i+1], bytes_q[4*i]});
      exp_sum = exp_sum + exp_words[i];
    end
`ifndef ONCHIP_MEM_LOADER_CHECKSUM_EN
    exp_sum = '0;
`endif
    wr_addr.delete();
    wr_data.delete();
    exact_spacing = !gap;
    e0 = err_cnt;
    d0 = done_cnt;
    pulse_start(ADDR_W'(base), CNT_W'(count));
    for (int unsigned i = 0; i < count * 4; i++) begin
      if (busy_start && i == 1) begin
        start      = 1'b1;
        base_addr  = '0;
        word_count = CNT_W'(1);
      end
      send_byte(bytes_q[i], gap);
      start = 1'b0;
    end
    got_done = 1'b0;
    for (int k = 0; k < 300 && !got_done; k++) begin
      @(posedge clk); #1;
      got_done = (done_cnt != d0);
    end
    if (!got_done) chk({tag, "_done_timeout"}, 32'h0, 32'h1);
    chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(count));
    for (int unsigned i = 0; i < count && i < wr_addr.size(); i++) begin
      chk({tag, "_addr"}, 32'(wr_addr[i]), 32'(base + i));
      chk({tag, "_data"}, wr_data[i], exp_words[i]);
    end
    chk({tag, "_no_error"}, 32'(err_cnt - e0), 32'h0);
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'h1);
    @(negedge clk);
    chk({tag, "_checksum"}, checksum, exp_sum);
    repeat (3) @(negedge clk);
    chk({tag, "_checksum_hold"}, checksum, exp_sum);
    chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic bad_start(input string tag, input int unsigned base, input int unsigned count);
    int e0;
    e0 = err_cnt;
    wr_addr.delete();
    wr_data.delete();
    pulse_start(ADDR_W'(base), CNT_W'(count));
    @(negedge clk);
    chk({tag, "_error_pulse"}, 32'(error), 32'h1);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'h0);
    @(negedge clk);
    chk({tag, "_error_clear"}, 32'(error), 32'h0);
    repeat (6) @(negedge clk);
    chk({tag, "_no_write"}, 32'(wr_addr.size()), 32'h0);
    chk({tag, "_error_count"}, 32'(err_cnt - e0), 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load("single", 0, 1, 1'b0, 1'b0);

    fill_random(2);
    run_load("top_edge", DEPTH - 2, 2, 1'b0, 1'b0);

    bad_start("over_end", DEPTH - 1, 2);
    bad_start("count_zero", 100, 0);
    bad_start("too_long", 0, DEPTH + 1);

    fill_random(3);
    run_load("gaps3", $urandom_range(0, DEPTH - 3), 3, 1'b1, 1'b0);

    fill_random(2);
    run_load("busy_start", 40, 2, 1'b0, 1'b1);

    bytes_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    run_load("csum_wrap", 7, 2, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int unsigned n;
      n = $urandom_range(1, 5);
      fill_random(n);
      run_load("random", $urandom_range(0, DEPTH - n), n, r[0], 1'b0);
    end

    // Reset after two of four bytes; the partial word must not leak into the next load.
    wr_addr.delete();
    wr_data.delete();
    pulse_start(ADDR_W'(20), CNT_W'(1));
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    chk_all_zero("in_reset");
    #2;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_no_write", 32'(wr_addr.size()), 32'h0);
    @(posedge clk); #1;
    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load("after_reset", 0, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
